div_issue_ctrl: RTL and testbench
=================================

DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 64, max cycles in WAIT before abort.
REQ-002 SHALL have one clock; reset is synchronous and active-high: clk  in  1  clock; reset  in  1  sync active-high reset.
REQ-003 SHALL have ports: req_valid  in  1  EX-stage request; req_ready  out  1  controller can accept.
REQ-004 SHALL have ports: req_op  in  alu_op_type  operation; req_op1, req_op2  in  XLEN_WIDTH  operands; req_rd  in  5  destination register.
REQ-005 SHALL have port: stall  out  1  pipeline hold.
REQ-006 SHALL have ports: div_start  out  1; div_operation  out  alu_op_type; div_operand1, div_operand2  out  XLEN_WIDTH.
REQ-007 SHALL have ports: div_result  in  XLEN_WIDTH; div_ready  in  1; div_exception  in  1.
REQ-008 SHALL have ports: wb_valid  out  1; wb_rd  out  5; wb_data  out  XLEN_WIDTH; wb_dbz  out  1  divide-by-zero flag.
REQ-009 SHALL have ports: flush  in  1  kill in-flight op; timeout_err  out  1  sticky abort flag.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT, DRAIN, RESP.
REQ-011 Div op SHALL mean req_op in {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU}; other ops are ignored with no state change.
REQ-012 req_ready SHALL be 1 only in IDLE with div_ready=1 and flush=0.
REQ-013 IDLE: on req_valid && req_ready && div op, SHALL latch op, operands and rd, then go to ISSUE.
REQ-014 ISSUE: div_start SHALL be 1 for exactly this one cycle; SHALL capture div_exception into the dbz register; next state WAIT.
REQ-015 div_operation/div_operand1/div_operand2 SHALL drive latched values and stay stable from ISSUE until leaving WAIT/DRAIN.
REQ-016 WAIT: div_ready=1 SHALL capture div_result and go to RESP; flush=1 SHALL go to DRAIN (flush has priority over div_ready).
REQ-017 WAIT: cycle counter SHALL start at 0 on entry; on reaching TIMEOUT_CYCLES it SHALL set timeout_err, go to IDLE and not assert wb_valid.
REQ-018 DRAIN: SHALL wait for div_ready=1, then go to IDLE with no writeback.
REQ-019 RESP: wb_valid SHALL pulse for one cycle with latched rd, result and dbz, then go to IDLE; flush in RESP SHALL suppress wb_valid.
REQ-020 stall SHALL be 1 in ISSUE and WAIT, and in IDLE/DRAIN while req_valid && div op is present but not accepted-and-issued; otherwise 0; it is 0 in RESP.
REQ-021 With a compliant divider (XLEN_WIDTH CALC cycles plus 2 DONE cycles), wb_valid SHALL occur at T+XLEN_WIDTH+4 after the accept cycle T (T+36 for XLEN 32).
REQ-022 wb_data and wb_rd SHALL hold their last values when wb_valid=0.
REQ-023 Divide-by-zero results SHALL be passed through from div_result unmodified, with wb_dbz=1.

Reset
REQ-024 Reset SHALL force IDLE and set all outputs, counter, latched registers and timeout_err to 0, including mid-operation, without waiting for the divider.
REQ-025 timeout_err SHALL clear only on reset.

Configuration
REQ-026 With DIV_RESULT_CACHE_EN defined, the block SHALL store the last completed {op, op1, op2, result, dbz}, valid after its first RESP.
REQ-027 With DIV_RESULT_CACHE_EN defined, an accepted request matching all stored fields SHALL go directly to RESP the next cycle with no div_start.
REQ-028 The cache SHALL be invalidated by reset only, not by flush or timeout, and SHALL not be updated on DRAIN or timeout.
REQ-029 Without DIV_RESULT_CACHE_EN, every accepted request SHALL be issued to the divider.

Structure
REQ-030 alu_op_type and XLEN_WIDTH SHALL come from package common; the state enum div_ctrl_state_t SHALL be added to common.
REQ-031 The cache SHALL be sub-module div_result_cache, instantiated only under DIV_RESULT_CACHE_EN; the controller is otherwise flat.

Verification
REQ-032 DIVU 100/7 accepted at T: one div_start pulse at T+1, wb_valid at T+36, wb_data=14, wb_rd=latched rd.
REQ-033 DIV -7/2 gives wb_data=0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF; stall stays 1 from T to T+35.
REQ-034 DIVU 9/0 gives wb_data=0xFFFFFFFF, wb_dbz=1; REMU 5/0 gives wb_data=5, wb_dbz=1.
REQ-035 Flush at T+10: no wb_valid; req_ready=0 until div_ready=1; next DIVU 8/2 gives wb_data=4.
REQ-036 div_ready held 0 after ISSUE: timeout_err=1 64 cycles into WAIT; FSM in IDLE; no wb_valid.
REQ-037 Cache: with DIV_RESULT_CACHE_EN, a repeat DIVU 100/7 gives wb_valid at T+1 with no div_start; without the macro, at T+36.

Source files
------------

// File: rtl/common_pkg.sv
// Shared types for the integer pipeline: ALU operation codes, datapath width
// and the divider issue controller state encoding.
package common;

    localparam int XLEN_WIDTH = 32;

    typedef enum logic [4:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alu_op_type;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN,
        RESP
    } div_ctrl_state_t;

    typedef struct packed {
        alu_op_type            op;
        logic [XLEN_WIDTH-1:0] op1;
        logic [XLEN_WIDTH-1:0] op2;
        logic [XLEN_WIDTH-1:0] result;
        logic                  dbz;
    } div_cache_entry_t;

    function automatic logic is_div_op(input alu_op_type op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/div_issue_ctrl_cache.sv
// Single-entry memo of the last completed division; only instantiated when
// DIV_RESULT_CACHE_EN is defined.
module div_result_cache
    import common::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  alu_op_type            wr_op,
    input  logic [XLEN_WIDTH-1:0] wr_op1,
    input  logic [XLEN_WIDTH-1:0] wr_op2,
    input  logic [XLEN_WIDTH-1:0] wr_result,
    input  logic                  wr_dbz,
    input  alu_op_type            lk_op,
    input  logic [XLEN_WIDTH-1:0] lk_op1,
    input  logic [XLEN_WIDTH-1:0] lk_op2,
    output logic                  hit,
    output logic [XLEN_WIDTH-1:0] hit_result,
    output logic                  hit_dbz
);

    div_cache_entry_t entry_q;
    logic             valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q <= '0;
            valid_q <= 1'b0;
        end else if (wr_en) begin
            entry_q.op     <= wr_op;
            entry_q.op1    <= wr_op1;
            entry_q.op2    <= wr_op2;
            entry_q.result <= wr_result;
            entry_q.dbz    <= wr_dbz;
            valid_q        <= 1'b1;
        end
    end

    assign hit        = valid_q && (entry_q.op == lk_op) && (entry_q.op1 == lk_op1) && (entry_q.op2 == lk_op2);
    assign hit_result = entry_q.result;
    assign hit_dbz    = entry_q.dbz;

endmodule

// File: rtl/div_issue_ctrl.sv
// Issues one division at a time from EX to an iterative divider and returns the
// result as a one-cycle writeback. Optional result memo: DIV_RESULT_CACHE_EN.
module div_issue_ctrl
    import common::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  alu_op_type            req_op,
    input  logic [XLEN_WIDTH-1:0] req_op1,
    input  logic [XLEN_WIDTH-1:0] req_op2,
    input  logic [4:0]            req_rd,
    output logic                  stall,
    output logic                  div_start,
    output alu_op_type            div_operation,
    output logic [XLEN_WIDTH-1:0] div_operand1,
    output logic [XLEN_WIDTH-1:0] div_operand2,
    input  logic [XLEN_WIDTH-1:0] div_result,
    input  logic                  div_ready,
    input  logic                  div_exception,
    output logic                  wb_valid,
    output logic [4:0]            wb_rd,
    output logic [XLEN_WIDTH-1:0] wb_data,
    output logic                  wb_dbz,
    input  logic                  flush,
    output logic                  timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    div_ctrl_state_t       state_q, state_d;
    alu_op_type            op_q, op_d;
    logic [XLEN_WIDTH-1:0] op1_q, op1_d;
    logic [XLEN_WIDTH-1:0] op2_q, op2_d;
    logic [4:0]            rd_q, rd_d;
    logic                  dbz_q, dbz_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [4:0]            wb_rd_q, wb_rd_d;
    logic [XLEN_WIDTH-1:0] wb_data_q, wb_data_d;
    logic                  wb_dbz_q, wb_dbz_d;
    logic                  timeout_q, timeout_d;

    logic                  req_is_div;
    logic                  accept;
    logic                  cache_hit;
    logic [XLEN_WIDTH-1:0] cache_result;
    logic                  cache_dbz;

    assign req_is_div = is_div_op(req_op);
    assign req_ready  = !reset && (state_q == IDLE) && div_ready && !flush;
    assign accept     = req_valid && req_ready && req_is_div;

`ifdef DIV_RESULT_CACHE_EN
    logic cache_wr;

    // Every RESP carries a finished result; hits rewrite identical contents.
    assign cache_wr = (state_q == RESP);

    div_result_cache u_cache (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (cache_wr),
        .wr_op      (op_q),
        .wr_op1     (op1_q),
        .wr_op2     (op2_q),
        .wr_result  (wb_data_q),
        .wr_dbz     (wb_dbz_q),
        .lk_op      (req_op),
        .lk_op1     (req_op1),
        .lk_op2     (req_op2),
        .hit        (cache_hit),
        .hit_result (cache_result),
        .hit_dbz    (cache_dbz)
    );
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
    assign cache_dbz    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        rd_d      = rd_q;
        dbz_d     = dbz_q;
        cnt_d     = cnt_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        wb_dbz_d  = wb_dbz_q;
        timeout_d = timeout_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d  = req_op;
                    op1_d = req_op1;
                    op2_d = req_op2;
                    rd_d  = req_rd;
                    if (cache_hit) begin
                        wb_data_d = cache_result;
                        wb_dbz_d  = cache_dbz;
                        wb_rd_d   = req_rd;
                        state_d   = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                dbz_d   = div_exception;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (flush) begin
                    state_d = DRAIN;
                end else if (div_ready) begin
                    wb_data_d = div_result;
                    wb_dbz_d  = dbz_q;
                    wb_rd_d   = rd_q;
                    state_d   = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (div_ready) begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are forced low during reset so EX never sees a spurious handshake.
    always_comb begin
        stall     = 1'b0;
        div_start = 1'b0;
        wb_valid  = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE, DRAIN: stall = req_valid && req_is_div;
                ISSUE: begin
                    stall     = 1'b1;
                    div_start = 1'b1;
                end
                WAIT:    stall = 1'b1;
                RESP:    wb_valid = !flush;
                default: stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= alu_op_type'('0);
            op1_q     <= '0;
            op2_q     <= '0;
            rd_q      <= '0;
            dbz_q     <= 1'b0;
            cnt_q     <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            wb_dbz_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            rd_q      <= rd_d;
            dbz_q     <= dbz_d;
            cnt_q     <= cnt_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            wb_dbz_q  <= wb_dbz_d;
            timeout_q <= timeout_d;
        end
    end

    assign div_operation = op_q;
    assign div_operand1  = op1_q;
    assign div_operand2  = op2_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign wb_dbz        = wb_dbz_q;
    assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: behavioural iterative divider plus a
// transaction-level reference model (latency, RISC-V division results, memo).
module tb_div_issue_ctrl;
    import common::*;

    localparam int TO  = 64;
    localparam int LAT = XLEN_WIDTH + 4;
`ifdef DIV_RESULT_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    alu_op_type            req_op = ALU_ADD;
    logic [XLEN_WIDTH-1:0] req_op1 = '0;
    logic [XLEN_WIDTH-1:0] req_op2 = '0;
    logic [4:0]            req_rd = '0;
    logic                  stall;
    logic                  div_start;
    alu_op_type            div_operation;
    logic [XLEN_WIDTH-1:0] div_operand1, div_operand2;
    logic [XLEN_WIDTH-1:0] div_result;
    logic                  div_ready;
    logic                  div_exception;
    logic                  wb_valid;
    logic [4:0]            wb_rd;
    logic [XLEN_WIDTH-1:0] wb_data;
    logic                  wb_dbz;
    logic                  flush = 1'b0;
    logic                  timeout_err;

    always #5 clk = ~clk;

    div_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_op1       (req_op1),
        .req_op2       (req_op2),
        .req_rd        (req_rd),
        .stall         (stall),
        .div_start     (div_start),
        .div_operation (div_operation),
        .div_operand1  (div_operand1),
        .div_operand2  (div_operand2),
        .div_result    (div_result),
        .div_ready     (div_ready),
        .div_exception (div_exception),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_dbz        (wb_dbz),
        .flush         (flush),
        .timeout_err   (timeout_err)
    );

    function automatic logic [XLEN_WIDTH-1:0] ref_div(input alu_op_type op,
                                                      input logic [XLEN_WIDTH-1:0] a,
                                                      input logic [XLEN_WIDTH-1:0] b);
        logic signed [XLEN_WIDTH-1:0] sa, sb, sq;
        logic [XLEN_WIDTH-1:0] res;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        res = '0;
        case (op)
            ALU_DIVU: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REMU: res = (b == 0) ? a : a % b;
            ALU_DIV: begin
                if (b == 0) res = 32'hFFFF_FFFF;
                else if (ovf) res = a;
                else begin sq = sa / sb; res = sq; end
            end
            ALU_REM: begin
                if (b == 0) res = a;
                else if (ovf) res = '0;
                else begin sq = sa % sb; res = sq; end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Behavioural divider: busy for XLEN+1 cycles after start, then ready with result.
    logic                  hang = 1'b0;
    logic                  dbusy;
    int                    dcnt;
    logic [XLEN_WIDTH-1:0] dres;
    alu_op_type            dop;
    logic [XLEN_WIDTH-1:0] da, db;

    assign div_ready     = !dbusy;
    assign div_result    = dres;
    assign div_exception = div_start && (div_operand2 == '0);

    always @(posedge clk) begin
        if (reset) begin
            dbusy <= 1'b0;
            dcnt  <= 0;
            dres  <= '0;
        end else if (div_start) begin
            dbusy <= 1'b1;
            dcnt  <= 0;
            dop   <= div_operation;
            da    <= div_operand1;
            db    <= div_operand2;
        end else if (dbusy) begin
            if (dcnt >= XLEN_WIDTH && !hang) begin
                dbusy <= 1'b0;
                dres  <= ref_div(dop, da, db);
            end else if (dcnt < XLEN_WIDTH) begin
                dcnt <= dcnt + 1;
            end
        end
    end

    int errors = 0;
    int checks = 0;
    int txn_no = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference memo of the last completed division.
    logic                  c_valid = 1'b0;
    alu_op_type            c_op = ALU_ADD;
    logic [XLEN_WIDTH-1:0] c_a = '0, c_b = '0;

    task automatic wait_idle();
        int n;
        n = 0;
        req_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clk); #1;
        while (!req_ready && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        if (!req_ready) check("idle_wait", {63'd0, req_ready}, 64'd1);
    endtask

    // flush_at: -1 none, 2..LAT-2 flush during WAIT, LAT flush during RESP.
    task automatic run_op(input alu_op_type op, input logic [XLEN_WIDTH-1:0] a,
                          input logic [XLEN_WIDTH-1:0] b, input logic [4:0] rd, input int flush_at);
        int n_start, start_k, wb_k, stall_bad, rdy_bad, exp_wb, slot;
        logic [XLEN_WIDTH-1:0] exp_d, got_d;
        logic [4:0] got_rd;
        logic got_dbz, hit, rdy_after, wait_flush;
        wait_idle();
        hit        = CACHE_EN && c_valid && (c_op == op) && (c_a == a) && (c_b == b);
        exp_d      = ref_div(op, a, b);
        slot       = hit ? 1 : LAT;
        wait_flush = (flush_at >= 0) && (flush_at < LAT);
        exp_wb     = (flush_at >= 0) ? -1 : slot;
        req_valid = 1'b1; req_op = op; req_op1 = a; req_op2 = b; req_rd = rd;
        #1;
        check("accept_ready", {63'd0, req_ready}, 64'd1);
        check("accept_stall", {63'd0, stall}, 64'd1);
        n_start = 0; start_k = -1; wb_k = -1; stall_bad = 0; rdy_bad = 0; rdy_after = 1'b0;
        got_d = '0; got_rd = '0; got_dbz = 1'b0;
        for (int k = 1; k <= LAT + 4; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            flush = (k == flush_at);
            #1;
            if (div_start) begin n_start++; start_k = k; end
            if (wb_valid && wb_k < 0) begin wb_k = k; got_d = wb_data; got_rd = wb_rd; got_dbz = wb_dbz; end
            if (!wait_flush && k < slot && !stall) stall_bad++;
            if (wait_flush && k <= LAT - 1 && req_ready) rdy_bad++;
            if (k == LAT) rdy_after = req_ready;
        end
        flush = 1'b0;
        check("start_count", 64'(n_start), hit ? 64'd0 : 64'd1);
        if (!hit) check("start_cycle", 64'(start_k), 64'd1);
        check("wb_cycle", 64'(wb_k), 64'(exp_wb));
        if (exp_wb > 0) begin
            check("wb_data", {32'd0, got_d}, {32'd0, exp_d});
            check("wb_rd", {59'd0, got_rd}, {59'd0, rd});
            check("wb_dbz", {63'd0, got_dbz}, {63'd0, (b == 0)});
            check("wb_data_hold", {32'd0, wb_data}, {32'd0, exp_d});
            check("stall_busy", 64'(stall_bad), 64'd0);
        end
        if (wait_flush) begin
            check("drain_ready_low", 64'(rdy_bad), 64'd0);
            check("drain_ready_back", {63'd0, rdy_after}, 64'd1);
        end
        if (!wait_flush) begin
            c_valid = 1'b1; c_op = op; c_a = a; c_b = b;
        end
        txn_no++;
        $display("txn %0d op=%s a=%08h b=%08h rd=%0d flush_at=%0d wb_at=%0d data=%08h dbz=%0b",
                 txn_no, op.name(), a, b, rd, flush_at, wb_k, got_d, got_dbz);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int to_k, wb_seen, bad;
        alu_op_type div_ops[4];
        alu_op_type op;
        logic [XLEN_WIDTH-1:0] a, b;
        int fl;
        div_ops[0] = ALU_DIV; div_ops[1] = ALU_DIVU; div_ops[2] = ALU_REM; div_ops[3] = ALU_REMU;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("rst_wb_data", {32'd0, wb_data}, 64'd0);
        check("rst_wb_rd", {59'd0, wb_rd}, 64'd0);
        check("rst_div_start", {63'd0, div_start}, 64'd0);
        check("rst_operands", {div_operand1, div_operand2}, 64'd0);
        check("rst_timeout", {63'd0, timeout_err}, 64'd0);
        reset = 1'b0;

        // Directed sequence
        run_op(ALU_DIVU, 32'd100, 32'd7, 5'd5, -1);
        run_op(ALU_DIVU, 32'd100, 32'd7, 5'd9, -1);
        run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3, -1);
        run_op(ALU_REM, 32'hFFFF_FFF9, 32'd2, 5'd4, -1);
        run_op(ALU_DIVU, 32'd9, 32'd0, 5'd10, -1);
        run_op(ALU_REMU, 32'd5, 32'd0, 5'd11, -1);
        run_op(ALU_DIVU, 32'd20, 32'd3, 5'd12, 10);
        run_op(ALU_DIVU, 32'd20, 32'd3, 5'd12, -1);
        run_op(ALU_DIVU, 32'd8, 32'd2, 5'd13, -1);
        run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, -1);
        run_op(ALU_REMU, 32'd77, 32'd10, 5'd15, LAT);

        // Non-division op is ignored
        wait_idle();
        req_valid = 1'b1; req_op = ALU_ADD; req_op1 = 32'd1; req_op2 = 32'd2;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            if (stall || div_start || wb_valid || !req_ready) bad++;
        end
        req_valid = 1'b0;
        check("non_div_ignored", 64'(bad), 64'd0);

        // Divider never answers: timeout
        wait_idle();
        hang = 1'b1;
        req_valid = 1'b1; req_op = ALU_DIVU; req_op1 = 32'd50; req_op2 = 32'd5; req_rd = 5'd6;
        #1;
        to_k = -1; wb_seen = 0;
        for (int k = 1; k <= TO + 8; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            if (timeout_err && to_k < 0) to_k = k;
            if (wb_valid) wb_seen++;
        end
        check("timeout_cycle", 64'(to_k), 64'(TO + 2));
        check("timeout_no_wb", 64'(wb_seen), 64'd0);
        hang = 1'b0;
        txn_no++;
        $display("txn %0d timeout: timeout_err at T+%0d, wb_valid seen %0d", txn_no, to_k, wb_seen);
        run_op(ALU_DIVU, 32'd8, 32'd2, 5'd13, -1);
        check("timeout_sticky", {63'd0, timeout_err}, 64'd1);

        // Randomized transactions
        for (int i = 0; i < 16; i++) begin
            op = div_ops[$urandom_range(0, 3)];
            a  = $urandom;
            case ($urandom_range(0, 3))
                0: b = '0;
                1: b = XLEN_WIDTH'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0 && c_valid) begin op = c_op; a = c_a; b = c_b; end
            fl = -1;
            if (!(CACHE_EN && c_valid && c_op == op && c_a == a && c_b == b) && $urandom_range(0, 5) == 0)
                fl = $urandom_range(2, 30);
            run_op(op, a, b, 5'($urandom_range(1, 31)), fl);
        end
        run_op(ALU_DIVU, 32'd8, 32'd2, 5'd13, -1);

        // Reset in the middle of an operation
        wait_idle();
        req_valid = 1'b1; req_op = ALU_DIVU; req_op1 = 32'h1234; req_op2 = 32'd3; req_rd = 5'd7;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        check("midrst_operand", {32'd0, div_operand1}, 64'd0);
        check("midrst_wb_data", {32'd0, wb_data}, 64'd0);
        check("midrst_wb_rd", {59'd0, wb_rd}, 64'd0);
        check("midrst_stall", {63'd0, stall}, 64'd0);
        check("midrst_timeout", {63'd0, timeout_err}, 64'd0);
        reset = 1'b0;
        c_valid = 1'b0;
        @(negedge clk); #1;
        check("midrst_ready", {63'd0, req_ready}, 64'd1);
        txn_no++;
        $display("txn %0d mid-operation reset", txn_no);
        run_op(ALU_DIVU, 32'd8, 32'd2, 5'd13, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
